pair_dist_engine: RTL and testbench

- Memory-mapped accelerator that computes the minimum or maximum absolute distance over all unordered pairs in a block of unsigned elements held in data memory.
- Reads a run-time-sized window of data memory into a local buffer, then evaluates one pair per cycle.
- Sits beside the data memory on a read port and is started and polled by the core through start/done.
- Generalises the closest-pair program in element width, depth, base address, count and mode, and adds zero-distance early exit.

---
 rtl/pair_dist_engine.sv | 207 ++++++++++++++++++++
 tb/tb_pair_dist_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pair_dist_engine.sv
// Minimum/maximum absolute pair-distance engine: loads a window of data memory
// into a local buffer, then evaluates every unordered pair at one pair per cycle.
module pair_dist_engine #(
    parameter int W     = 8,
    parameter int AW    = 8,
    parameter int MAX_N = 32,
    localparam int CW   = $clog2(MAX_N + 1),
    localparam int PW   = $clog2(MAX_N * (MAX_N - 1) / 2 + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] count,
    input  logic          mode,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [W-1:0]  mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [PW-1:0] pairs
);

    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[W]) begin
            abs_diff = b - a;
        end else begin
            abs_diff = diff[W-1:0];
        end
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [AW-1:0] mem_addr_r;
    logic          mem_rd_r;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  result_r;
    logic [PW-1:0] pairs_r;
    logic [W-1:0]  acc_r;
    logic [PW-1:0] pcnt_r;
    logic          mode_r;
    logic [CW-1:0] n_r;
    logic [IW-1:0] ld_idx_r;
    logic [IW-1:0] k_r;
    logic [IW-1:0] j_r;
    logic [W-1:0]  buf_r [MAX_N];

    logic [CW-1:0] n_in_s;
    logic [IW-1:0] last_idx_s;
    logic          start_ok_s;
    logic          load_last_s;
    logic          scan_last_s;
    logic          row_end_s;
    logic          early_exit_s;
    logic          better_s;
    logic [W-1:0]  dist_s;

    // Run-control decode and pair datapath
    always_comb begin
        n_in_s       = (count > CW'(MAX_N)) ? CW'(MAX_N) : count;
        last_idx_s   = IW'(n_r - CW'(1));
        // the done_r term blocks a start landing in the completion cycle
        start_ok_s   = start && (state_r == ST_IDLE) && !done_r;
        load_last_s  = (ld_idx_r == last_idx_s);
        dist_s       = abs_diff(buf_r[k_r], buf_r[j_r]);
        row_end_s    = (j_r == (k_r - IW'(1)));
        scan_last_s  = (k_r == last_idx_s) && row_end_s;
        early_exit_s = !mode_r && (dist_s == {W{1'b0}});
        if (mode_r) begin
            better_s = (dist_s > acc_r);
        end else begin
            better_s = (dist_s < acc_r);
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = (n_in_s >= CW'(2)) ? ST_LOAD : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: state_next_s = ST_SCAN;
            ST_SCAN: begin
                if (early_exit_s || scan_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, run context, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            mem_addr_r <= {AW{1'b0}};
            mem_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {W{1'b0}};
            pairs_r    <= {PW{1'b0}};
            acc_r      <= {W{1'b0}};
            pcnt_r     <= {PW{1'b0}};
            mode_r     <= 1'b0;
            n_r        <= {CW{1'b0}};
            ld_idx_r   <= {IW{1'b0}};
            k_r        <= {IW{1'b0}};
            j_r        <= {IW{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_LOAD) || (state_next_s == ST_DRAIN) ||
                       (state_next_s == ST_SCAN);
            done_r  <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        mode_r     <= mode;
                        n_r        <= n_in_s;
                        acc_r      <= mode ? {W{1'b0}} : {W{1'b1}};
                        pcnt_r     <= {PW{1'b0}};
                        ld_idx_r   <= {IW{1'b0}};
                        mem_addr_r <= base_addr;
                        mem_rd_r   <= (n_in_s >= CW'(2));
                    end
                end
                ST_LOAD: begin
                    ld_idx_r <= ld_idx_r + IW'(1);
                    if (load_last_s) begin
                        mem_rd_r <= 1'b0;
                    end else begin
                        mem_rd_r   <= 1'b1;
                        mem_addr_r <= mem_addr_r + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    k_r <= IW'(1);
                    j_r <= {IW{1'b0}};
                end
                ST_SCAN: begin
                    pcnt_r <= pcnt_r + PW'(1);
                    if (better_s) begin
                        acc_r <= dist_s;
                    end
                    if (row_end_s) begin
                        k_r <= k_r + IW'(1);
                        j_r <= {IW{1'b0}};
                    end else begin
                        j_r <= j_r + IW'(1);
                    end
                end
                ST_DONE: begin
                    result_r <= acc_r;
                    pairs_r  <= pcnt_r;
                end
                default: begin
                    mode_r <= mode_r;
                end
            endcase
        end
    end

    // Element buffer: read data trails its address by one cycle
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOAD) && (ld_idx_r != {IW{1'b0}})) begin
            buf_r[ld_idx_r - IW'(1)] <= mem_rdata;
        end else if (state_r == ST_DRAIN) begin
            buf_r[last_idx_s] <= mem_rdata;
        end
    end

    assign mem_addr = mem_addr_r;
    assign mem_rd   = mem_rd_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign pairs    = pairs_r;

endmodule

// File: tb/tb_pair_dist_engine.sv
// Directed bench for pair_dist_engine with a scoreboard of expected run results
// and expected read addresses, built from a nested-loop reference model.
module tb_pair_dist_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [5:0] count;
    logic       mode;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [8:0] pairs;

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] res;
        int         prs;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] addr_q[$];

    pair_dist_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mode      (mode),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .pairs     (pairs)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory
    always @(posedge clk) begin
        if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [7:0] b, input int n, input logic m,
                                  output logic [7:0] r, output int p);
        logic [7:0] ia, ic, a, c, d;
        bit stop;
        r = m ? 8'h00 : 8'hFF;
        p = 0;
        stop = 1'b0;
        for (int k = 1; k < n; k++) begin
            for (int j = 0; j < k; j++) begin
                if (!stop) begin
                    ia = b + 8'(k);
                    ic = b + 8'(j);
                    a = mem[ia];
                    c = mem[ic];
                    d = (a > c) ? a - c : c - a;
                    p++;
                    if (m ? (d > r) : (d < r)) r = d;
                    if (!m && d == 8'd0) stop = 1'b1;
                end
            end
        end
    endfunction

    task automatic run(input logic [7:0] b, input logic [5:0] c, input logic m,
                       input bit glitch, input bit poke, input string tag);
        int n, lat, p;
        exp_t e;
        logic [7:0] r;
        logic [31:0] exp_addr;
        n = (c > 6'd32) ? 32 : int'(c);
        model(b, n, m, r, p);
        e.res = r;
        e.prs = p;
        e.lat = (n < 2) ? 1 : n + 1 + p + 1;
        exp_q.push_back(e);
        if (n >= 2) for (int i = 0; i < n; i++) addr_q.push_back(b + 8'(i));
        @(negedge clk);
        base_addr = b; count = c; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            if (mem_rd === 1'b1) begin
                exp_addr = (addr_q.size() > 0) ? 32'(addr_q.pop_front()) : 32'hDEAD;
                chk({tag, "_addr"}, 32'(mem_addr), exp_addr);
            end
            if (glitch && lat == 1) begin
                start = 1'b1; base_addr = 8'h00; count = 6'd0; mode = ~m;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; base_addr = b; count = c; mode = m;
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_result"}, 32'(result), 32'(e.res));
        chk({tag, "_pairs"}, 32'(pairs), 32'(e.prs));
        chk({tag, "_reads_missing"}, 32'(addr_q.size()), 32'd0);
        addr_q.delete();
        if (poke) begin
            start = 1'b1; count = 6'd0; mode = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'({done, busy}), 32'd0);
        chk({tag, "_result_hold"}, 32'(result), 32'(e.res));
    endtask

    initial begin
        bit seen;
        reset = 1'b0; start = 1'b0; base_addr = 8'h00; count = 6'd0; mode = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h80] = 8'd10; mem[8'h81] = 8'd50; mem[8'h82] = 8'd23; mem[8'h83] = 8'd47;
        mem[8'h10] = 8'd5;  mem[8'h11] = 8'd9;  mem[8'h12] = 8'd5;  mem[8'h13] = 8'd100;
        for (int i = 0; i < 40; i++) mem[8'h20 + i] = 8'(i * 7);
        for (int i = 0; i < 8; i++) mem[8'h60 + i] = 8'(i * 30);
        mem[8'hFE] = 8'd200; mem[8'hFF] = 8'd3; mem[8'h00] = 8'd77; mem[8'h01] = 8'd90;
        void'($urandom(23));
        for (int i = 0; i < 20; i++) mem[8'hA0 + i] = 8'($urandom_range(147, 128));

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_pairs", 32'(pairs), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(8'h80, 6'd4, 1'b0, 1'b1, 1'b0, "min");
        run(8'h80, 6'd4, 1'b1, 1'b0, 1'b1, "max");
        run(8'h10, 6'd4, 1'b0, 1'b0, 1'b0, "early");
        run(8'h80, 6'd1, 1'b0, 1'b0, 1'b0, "n1");
        run(8'h80, 6'd0, 1'b0, 1'b0, 1'b0, "n0");
        run(8'h20, 6'd40, 1'b0, 1'b0, 1'b0, "sat");
        run(8'hFE, 6'd4, 1'b0, 1'b0, 1'b0, "wrap");

        // Abort a run in the middle of its pair scan
        @(negedge clk);
        base_addr = 8'h60; count = 6'd8; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_pairs", 32'(pairs), 32'd0);
        chk("arst_mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("arst_stays_idle", 32'(seen), 32'd0);

        run(8'hA0, 6'd20, 1'b0, 1'b0, 1'b0, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
